// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: tracks EX/MEM/WB destinations,
// selects ID-stage operand bypass sources, and issues load-use stalls, flushes and freezes.
`timescale 1ns/1ps
module hazard_fwd_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_wreg,
  input  logic             id_load,
  input  logic             id_br_taken,
  input  logic             mem_busy,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic            vld;
    logic [RA_W-1:0] rd;
    logic            wreg;
    logic            load;
  } stage_t;

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_e;

  stage_t           ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic busy;
  logic lu_hazard;

  function automatic logic stage_hit(input stage_t s, input logic [RA_W-1:0] r,
                                     input logic use_r);
    return s.vld & s.wreg & (s.rd == r) & (r != '0) & use_r;
  endfunction

  // A load still in EX has no data yet; it is covered by the load-use stall instead.
  function automatic logic [1:0] fwd_sel(input stage_t ex_s, input stage_t mem_s,
                                         input logic [RA_W-1:0] r, input logic use_r);
    logic [1:0] sel;
    sel = 2'b00;
    if (stage_hit(ex_s, r, use_r) && !ex_s.load) sel = 2'b01;
    else if (stage_hit(mem_s, r, use_r))         sel = mem_s.load ? 2'b11 : 2'b10;
    return sel;
  endfunction

  // Controls are combinational, so gate the live inputs with rst_n to force reset values
  // on the outputs for the whole time reset is held.
  assign busy      = mem_busy & rst_n;
  assign lu_hazard = id_valid & ex_q.load &
                     (stage_hit(ex_q, id_rs, id_use_rs) | stage_hit(ex_q, id_rt, id_use_rt));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    fwda        = fwd_sel(ex_q, mem_q, id_rs, id_use_rs);
    fwdb        = fwd_sel(ex_q, mem_q, id_rt, id_use_rt);
    pc_wen      = 1'b1;
    ifid_wen    = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    pipe_freeze = 1'b0;
    if (busy) begin
      pc_wen      = 1'b0;
      ifid_wen    = 1'b0;
      pipe_freeze = 1'b1;
    end else if (lu_hazard) begin
      pc_wen      = 1'b0;
      ifid_wen    = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      ifid_flush  = id_br_taken & id_valid & rst_n;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      state_d = busy ? MEM_WAIT : (lu_hazard ? LU_STALL : RUN);
      LU_STALL: state_d = busy ? MEM_WAIT : RUN;
      MEM_WAIT: state_d = busy ? MEM_WAIT : RUN;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!pipe_freeze) begin
      ex_d.vld  = id_valid & ~idex_bubble;
      ex_d.rd   = id_rd;
      ex_d.wreg = id_wreg;
      ex_d.load = id_load;
      mem_d     = ex_q;
      wb_d      = mem_q;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_wen && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

  // WB is tracked for completeness but never forwarded: the regfile writes in the first half-cycle.
  logic unused_wb;
  assign unused_wb = ^wb_q;

endmodule
